muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/HI/LO width; only 32 is supported.
REQ-002 SHALL have port clk  in  1  single clock; all state changes on posedge.
REQ-003 SHALL have port reset  in  1  synchronous active-high reset.
REQ-004 SHALL have port start  in  1  issue request, sampled on posedge.
REQ-005 SHALL have port op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 SHALL have ports a, b  in  WIDTH  operands; a is multiplicand or dividend.
REQ-007 SHALL have port flush  in  1  abort the in-flight operation.
REQ-008 SHALL have ports wr_hi, wr_lo  in  1  direct HI/LO write (MTHI/MTLO).
REQ-009 SHALL have port wdata  in  WIDTH  direct write data.
REQ-010 SHALL have port stall  out  1  combinational; drives the pipeline-register enable low.
REQ-011 SHALL have port done  out  1  one-cycle result-valid pulse.
REQ-012 SHALL have ports hi, lo  out  WIDTH  architectural HI/LO registers.

Function
REQ-013 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-014 IDLE or DONE with start=1 and flush=0 SHALL latch operand magnitudes and sign flags, clear the 5-bit iteration counter, and go to CALC.
REQ-015 IDLE or DONE without a start SHALL go to IDLE.
REQ-016 CALC SHALL perform one shift-add (multiply) or one restoring-subtract (divide) step per cycle; after 32 steps (counter=31) it SHALL go to FIX.
REQ-017 FIX SHALL apply sign correction, write hi/lo, and go to DONE.
REQ-018 Latency: start sampled at edge N -> hi/lo updated at edge N+33 -> done=1 for exactly the cycle after edge N+33.
REQ-019 stall SHALL be 1 exactly when the state is CALC or FIX (33 cycles per operation), and 0 otherwise.
REQ-020 start while in CALC or FIX SHALL be ignored; the upstream stage holds it under stall.
REQ-021 MULT/MULTU SHALL set {hi,lo} to the full 64-bit signed/unsigned product.
REQ-022 DIV/DIVU SHALL set lo = quotient truncated toward zero and hi = remainder; the remainder takes the sign of a.
REQ-023 Signed magnitude of 0x80000000 SHALL be treated as unsigned 0x80000000; the result is negated iff the sign flags differ (MULT/DIV quotient).
REQ-024 Divide by zero (b=0) SHALL give hi=a and lo=0xFFFFFFFF, with the same 33-cycle latency.
REQ-025 DIV 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0 (wrap, no trap).
REQ-026 flush=1 in CALC or FIX SHALL return to IDLE at the next edge, leave hi/lo unchanged, and suppress done.
REQ-027 flush=1 together with start SHALL take priority; no operation starts.
REQ-028 wr_hi/wr_lo SHALL update hi/lo at the edge only in IDLE or DONE, and SHALL be ignored in CALC or FIX.
REQ-029 A write concurrent with start SHALL be applied, and the operation SHALL also start.

Reset
REQ-030 reset=1 at a posedge SHALL force state=IDLE, hi=0, lo=0, counter=0, and internal accumulators to 0.
REQ-031 After reset, stall=0 and done=0 SHALL hold from the following cycle, including when reset lands mid-CALC.
REQ-032 reset SHALL dominate start, flush, and writes.

Structure
REQ-033 Package muldiv_pkg SHALL hold the op encodings, the FSM state encoding, WIDTH=32, and ITER=32.
REQ-034 Combinational sub-module muldiv_signfix SHALL compute operand magnitudes and the final negation of the quotient/product and remainder.
REQ-035 The datapath SHALL use one 64-bit accumulator/remainder register shared by multiply and divide; no array multiplier.

Verification
REQ-036 MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; stall high 33 cycles; done 1 cycle after edge N+33.
REQ-037 MULT -3 x 7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; then DIV -7/2 started in the DONE cycle -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-038 DIVU 7/0 -> hi=7, lo=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-039 MULTU 5x6 with flush at cycle 10 -> no done pulse, hi/lo keep their prior values, stall=0 next cycle; start at cycle 5 during busy -> ignored.
REQ-040 reset at cycle 5 of DIVU -> hi=lo=0, stall=0, done never pulses; wr_lo=1, wdata=0x1234 in IDLE -> lo=0x1234 next cycle.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared widths, op/state encodings and a negate helper for the multiply/divide unit
package muldiv_pkg;
  localparam int WIDTH = 32;
  localparam int ITER = 32;
  typedef enum logic [1:0] {OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11} op_e;
  typedef enum logic [1:0] {S_IDLE = 2'b00, S_CALC = 2'b01, S_FIX = 2'b10, S_DONE = 2'b11} state_e;
  function automatic logic [WIDTH-1:0] neg_if(input logic n, input logic [WIDTH-1:0] v);
    return n ? -v : v;
  endfunction
endpackage

// File: rtl/muldiv_signfix.sv
// muldiv_signfix: operand magnitudes on issue and sign correction of the final product/quotient/remainder
module muldiv_signfix
  import muldiv_pkg::*;
(
  input  logic [1:0]         i_op,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [WIDTH-1:0]   o_mag_a,
  output logic [WIDTH-1:0]   o_mag_b,
  output logic               o_sign_a,
  output logic               o_sign_b,
  input  logic               i_div,
  input  logic               i_sa,
  input  logic               i_sb,
  input  logic               i_dz,
  input  logic [2*WIDTH-1:0] i_acc,
  output logic [WIDTH-1:0]   o_hi,
  output logic [WIDTH-1:0]   o_lo
);
  logic               w_signed;
  logic [2*WIDTH-1:0] w_prod;
  assign w_signed = (i_op == OP_MULT) || (i_op == OP_DIV);
  assign o_sign_a = w_signed & i_a[WIDTH-1];
  assign o_sign_b = w_signed & i_b[WIDTH-1];
  // 0x80000000 negates to itself, which is exactly its unsigned magnitude
  assign o_mag_a  = neg_if(o_sign_a, i_a);
  assign o_mag_b  = neg_if(o_sign_b, i_b);
  assign w_prod   = (i_sa ^ i_sb) ? -i_acc : i_acc;
  // remainder follows the dividend; divide-by-zero forces an all-ones quotient
  assign o_hi = i_div ? neg_if(i_sa, i_acc[2*WIDTH-1:WIDTH]) : w_prod[2*WIDTH-1:WIDTH];
  assign o_lo = i_div ? (i_dz ? '1 : neg_if(i_sa ^ i_sb, i_acc[WIDTH-1:0])) : w_prod[WIDTH-1:0];
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: 33-cycle iterative MULT/MULTU/DIV/DIVU with architectural HI/LO and a pipeline stall
module muldiv_unit #(
  parameter int WIDTH = muldiv_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  import muldiv_pkg::*;
  state_e             r_state;
  logic [4:0]         r_cnt;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd, r_hi, r_lo;
  logic               r_div, r_sa, r_sb, r_dz;
  logic               w_free, w_sa, w_sb, w_ge;
  logic [WIDTH-1:0]   w_mag_a, w_mag_b, w_fix_hi, w_fix_lo, w_nrem;
  logic [WIDTH:0]     w_sum, w_rem;
  logic [2*WIDTH-1:0] w_step;
  muldiv_signfix u_signfix (
    .i_op(op), .i_a(a), .i_b(b),
    .o_mag_a(w_mag_a), .o_mag_b(w_mag_b), .o_sign_a(w_sa), .o_sign_b(w_sb),
    .i_div(r_div), .i_sa(r_sa), .i_sb(r_sb), .i_dz(r_dz), .i_acc(r_acc),
    .o_hi(w_fix_hi), .o_lo(w_fix_lo)
  );
  assign w_free = (r_state == S_IDLE) || (r_state == S_DONE);
  // multiply: {partial product, multiplier} shifts right; divide: {remainder, quotient} shifts left
  assign w_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd & {WIDTH{r_acc[0]}}};
  assign w_rem  = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_ge   = w_rem >= {1'b0, r_opnd};
  assign w_nrem = w_ge ? w_rem[WIDTH-1:0] - r_opnd : w_rem[WIDTH-1:0];
  assign w_step = r_div ? {w_nrem, r_acc[WIDTH-2:0], w_ge} : {w_sum, r_acc[WIDTH-1:1]};
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
      r_opnd  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_div   <= 1'b0;
      r_sa    <= 1'b0;
      r_sb    <= 1'b0;
      r_dz    <= 1'b0;
    end else begin
      if (w_free && wr_hi) r_hi <= wdata;
      if (w_free && wr_lo) r_lo <= wdata;
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start && !flush) begin
            r_state <= S_CALC;
            r_cnt   <= '0;
            r_div   <= op[1];
            r_sa    <= w_sa;
            r_sb    <= w_sb;
            r_dz    <= (b == '0);
            r_opnd  <= op[1] ? w_mag_b : w_mag_a;
            r_acc   <= {{WIDTH{1'b0}}, op[1] ? w_mag_a : w_mag_b};
          end else r_state <= S_IDLE;
        end
        S_CALC: begin
          if (flush) r_state <= S_IDLE;
          else begin
            r_acc <= w_step;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'(ITER-1)) r_state <= S_FIX;
          end
        end
        S_FIX: begin
          if (!flush) begin
            r_hi <= w_fix_hi;
            r_lo <= w_fix_lo;
          end
          r_state <= flush ? S_IDLE : S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign stall = (r_state == S_CALC) || (r_state == S_FIX);
  assign done  = (r_state == S_DONE);
  assign hi    = r_hi;
  assign lo    = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors with hand-computed HI/LO, latency, flush and reset checks
module tb_muldiv_unit;
  logic        clk = 1'b0, reset = 1'b1, start = 1'b0, flush = 1'b0, wr_hi = 1'b0, wr_lo = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0, wdata = '0, hi, lo;
  logic        stall, done;
  int          n_assert = 0, n_fail = 0, n, nd, ns;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata), .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    op = o; a = x; b = y; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    while (stall === 1'b1 && cnt < 100) begin
      cnt++;
      tick();
    end
  endtask

  task automatic watch(input int cycles, output int dcnt, output int scnt);
    dcnt = 0; scnt = 0;
    for (int i = 0; i < cycles; i++) begin
      if (done === 1'b1) dcnt++;
      if (stall === 1'b1) scnt++;
      tick();
    end
  endtask

  initial begin
    tick(); tick();
    reset = 1'b0;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_done", 32'(done), 32'h0);

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    chk("multu_done_busy", 32'(done), 32'h0);
    wait_done(n);
    chk("multu_stall_cycles", n, 33);
    chk("multu_done", 32'(done), 32'h1);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);
    tick();
    chk("multu_done_pulse", 32'(done), 32'h0);

    issue(2'b00, 32'hFFFF_FFFD, 32'd7);
    wait_done(n);
    chk("mult_done", 32'(done), 32'h1);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFEB);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    chk("div_b2b_stall", 32'(stall), 32'h1);
    wait_done(n);
    chk("div_b2b_cycles", n, 33);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    issue(2'b11, 32'd7, 32'd0);
    wait_done(n);
    chk("divu0_cycles", n, 33);
    chk("divu0_hi", hi, 32'd7);
    chk("divu0_lo", lo, 32'hFFFF_FFFF);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(n);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'h0);
    issue(2'b10, 32'hFFFF_FFF8, 32'd0);
    wait_done(n);
    chk("div0neg_hi", hi, 32'hFFFF_FFF8);
    chk("div0neg_lo", lo, 32'hFFFF_FFFF);
    issue(2'b11, 32'hFFFF_FFFF, 32'h10);
    wait_done(n);
    chk("divu_big_lo", lo, 32'h0FFF_FFFF);
    chk("divu_big_hi", hi, 32'hF);
    issue(2'b00, 32'h8000_0000, 32'h8000_0000);
    wait_done(n);
    chk("mult_min_hi", hi, 32'h4000_0000);
    chk("mult_min_lo", lo, 32'h0);

    tick();
    wr_hi = 1'b1; wr_lo = 1'b1; wdata = 32'h0000_AAAA;
    tick();
    wr_lo = 1'b0; wdata = 32'h0000_5555;
    wr_hi = 1'b0; wr_lo = 1'b1;
    tick();
    wr_lo = 1'b0;
    chk("wr_hi", hi, 32'h0000_AAAA);
    chk("wr_lo", lo, 32'h0000_5555);

    issue(2'b01, 32'd5, 32'd6);
    repeat (4) tick();
    start = 1'b1; a = 32'd9; b = 32'd9;
    wr_hi = 1'b1; wdata = 32'hDEAD_BEEF;
    tick();
    start = 1'b0; wr_hi = 1'b0;
    chk("busy_stall", 32'(stall), 32'h1);
    chk("busy_wr_ignored", hi, 32'h0000_AAAA);
    repeat (3) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_stall", 32'(stall), 32'h0);
    chk("flush_done", 32'(done), 32'h0);
    watch(40, nd, ns);
    chk("flush_no_done", nd, 0);
    chk("flush_no_restart", ns, 0);
    chk("flush_hi", hi, 32'h0000_AAAA);
    chk("flush_lo", lo, 32'h0000_5555);

    start = 1'b1; flush = 1'b1; op = 2'b01; a = 32'd2; b = 32'd2;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush_start_stall", 32'(stall), 32'h0);

    wr_lo = 1'b1; wdata = 32'h77;
    issue(2'b01, 32'd3, 32'd4);
    wr_lo = 1'b0;
    chk("wr_start_lo", lo, 32'h77);
    chk("wr_start_stall", 32'(stall), 32'h1);
    wait_done(n);
    chk("wr_start_res_lo", lo, 32'd12);
    chk("wr_start_res_hi", hi, 32'd0);

    issue(2'b11, 32'd100, 32'd7);
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    chk("midrst_stall", 32'(stall), 32'h0);
    chk("midrst_done", 32'(done), 32'h0);
    watch(40, nd, ns);
    chk("midrst_no_done", nd, 0);
    chk("midrst_no_stall", ns, 0);
    wr_lo = 1'b1; wdata = 32'h1234;
    tick();
    wr_lo = 1'b0;
    chk("idle_wr_lo", lo, 32'h1234);
    chk("idle_wr_hi_kept", hi, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
